fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 36 +++
 rtl/fetch_unit.sv | 167 ++++++++++++++++
 tb/tb_fetch_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if -- instruction-memory request/response bus of the fetch unit.
//
// Signals
//   imem_req    fetch side -> memory   request valid
//   imem_addr   fetch side -> memory   word-aligned request address
//   imem_ack    memory -> fetch side   response valid; completes the request
//                                      in the cycle it is high with imem_req
//   imem_rdata  memory -> fetch side   instruction word, valid with imem_ack
//
// Modports
//   master  the fetch unit (drives req/addr)
//   slave   the instruction memory (drives ack/rdata)
// ---------------------------------------------------------------------------
interface fetch_unit_if #(
  parameter int DWIDTH = 32
);
  logic              imem_req;
  logic [DWIDTH-1:0] imem_addr;
  logic              imem_ack;
  logic [31:0]       imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit -- IF stage of the pipeline.
//
// Issues word-aligned requests to the instruction memory, holds one fetched
// instruction for the decode stage and reacts to the hazard controller's
// IF-stage command (pipe / stall / flush / jump). A redirect that arrives
// while a request is still outstanding cannot cancel that request on the
// bus, so the unit waits for its response in DROP, discards the data and
// then fetches from the most recent redirect target.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   synchronous, active-high reset
//   if_ctrl     in   IF command: 00 pipe, 01 stall, 10 flush, 11 jump
//   jump_pc     in   redirect target (used only with jump; low bits ignored)
//   imem        bus  fetch_unit_if.master (imem_req/addr out, ack/rdata in)
//   if_valid    out  if_pc/if_inst hold a fetched instruction
//   if_pc       out  address of the presented instruction
//   if_inst     out  presented instruction
//   fetch_busy  out  request outstanding with nothing held (stall source)
//
// imem_req/imem_addr are registers, so neither if_ctrl/jump_pc nor imem_ack
// has a combinational path to the memory bus or to fetch_busy.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int                DWIDTH   = 32,
  parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        if_ctrl,
  input  logic [DWIDTH-1:0] jump_pc,
  fetch_unit_if.master      imem,
  output logic              if_valid,
  output logic [DWIDTH-1:0] if_pc,
  output logic [31:0]       if_inst,
  output logic              fetch_busy
);

  localparam logic [1:0] C_PIPE  = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;
  localparam logic [1:0] C_JUMP  = 2'b11;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_HOLD = 2'b10,
    S_DROP = 2'b11
  } state_t;

  state_t            state_q,    state_d;
  logic              req_q,      req_d;
  logic [DWIDTH-1:0] addr_q,     addr_d;
  logic [DWIDTH-1:0] pend_q,     pend_d;
  logic              valid_q,    valid_d;
  logic [DWIDTH-1:0] pc_q,       pc_d;
  logic [31:0]       inst_q,     inst_d;

  logic              redir;
  logic [DWIDTH-1:0] jump_tgt;

  // Clearing the two low bits by masking keeps every bit of jump_pc in use.
  assign jump_tgt = jump_pc & ~DWIDTH'(3);
  assign redir    = (if_ctrl == C_JUMP) || (if_ctrl == C_FLUSH);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    addr_d  = addr_q;
    pend_d  = pend_q;
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;

    unique case (state_q)
      S_IDLE: begin
        // addr_q already holds RESET_PC from reset.
        state_d = S_REQ;
        req_d   = 1'b1;
      end

      S_REQ: begin
        if (redir) begin
          valid_d = 1'b0;
          if (imem.imem_ack) begin
            // Response completes this cycle, so the bus is free to move on.
            addr_d  = (if_ctrl == C_JUMP) ? jump_tgt : addr_q;
            state_d = S_REQ;
          end else begin
            // Request must still complete on the bus with its old address.
            pend_d  = (if_ctrl == C_JUMP) ? jump_tgt : addr_q;
            state_d = S_DROP;
          end
        end else if (imem.imem_ack) begin
          pc_d    = addr_q;
          inst_d  = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_HOLD;
        end
      end

      S_HOLD: begin
        unique case (if_ctrl)
          C_STALL: ;
          C_PIPE: begin
            valid_d = 1'b0;
            addr_d  = pc_q + DWIDTH'(4);
            req_d   = 1'b1;
            state_d = S_REQ;
          end
          default: begin
            valid_d = 1'b0;
            addr_d  = (if_ctrl == C_JUMP) ? jump_tgt : pc_q;
            req_d   = 1'b1;
            state_d = S_REQ;
          end
        endcase
      end

      S_DROP: begin
        if (redir) begin
          // Latest redirect wins. A flush here refetches the instruction
          // already pending, since the one on the bus is being thrown away.
          pend_d  = (if_ctrl == C_JUMP) ? jump_tgt : pend_q;
          state_d = S_DROP;
        end else if (imem.imem_ack) begin
          addr_d  = pend_q;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      pend_q  <= RESET_PC;
      valid_q <= 1'b0;
      pc_q    <= RESET_PC;
      inst_q  <= NOP_INST;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign if_valid       = valid_q;
  assign if_pc          = pc_q;
  assign if_inst        = inst_q;
  assign fetch_busy     = ((state_q == S_REQ) || (state_q == S_DROP)) && !valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit -- directed self-checking bench for fetch_unit.
// Inputs change 1 time unit after each rising edge; outputs are checked at
// that same point, i.e. they show the state registered by the edge just past.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [1:0] C_PIPE  = 2'b00;
  localparam logic [1:0] C_STALL = 2'b01;
  localparam logic [1:0] C_FLUSH = 2'b10;
  localparam logic [1:0] C_JUMP  = 2'b11;

  logic        clk;
  logic        rst;
  logic [1:0]  if_ctrl;
  logic [31:0] jump_pc;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        fetch_busy;

  int checks;
  int errors;

  fetch_unit_if #(.DWIDTH(32)) imem ();

  fetch_unit #(.DWIDTH(32), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .if_ctrl    (if_ctrl),
    .jump_pc    (jump_pc),
    .imem       (imem.master),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .fetch_busy (fetch_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic chk_bus(input string tag, input logic req, input logic [31:0] addr,
                         input logic busy);
    chk({tag, ".req"},  {31'd0, imem.imem_req}, {31'd0, req});
    chk({tag, ".addr"}, imem.imem_addr, addr);
    chk({tag, ".busy"}, {31'd0, fetch_busy}, {31'd0, busy});
  endtask

  task automatic chk_if(input string tag, input logic vld, input logic [31:0] pc,
                        input logic [31:0] inst);
    chk({tag, ".vld"},  {31'd0, if_valid}, {31'd0, vld});
    chk({tag, ".pc"},   if_pc, pc);
    chk({tag, ".inst"}, if_inst, inst);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Reset with an ack and a jump pending: both must be ignored.
    rst = 1'b1;
    if_ctrl = C_JUMP;
    jump_pc = 32'h0000_0500;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hDEAD_BEEF;
    step();
    step();
    chk_bus("rst", 1'b0, 32'h0, 1'b0);
    chk_if("rst", 1'b0, 32'h0, 32'h0000_0013);

    // Release: IDLE -> REQ at RESET_PC.
    rst = 1'b0;
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b0;
    step();
    chk_bus("req0", 1'b1, 32'h0, 1'b1);
    chk("req0.vld", {31'd0, if_valid}, 32'd0);

    // Ack held off for three cycles in total: address and busy stay put.
    for (int i = 0; i < 2; i++) begin
      step();
      chk_bus("wait", 1'b1, 32'h0, 1'b1);
    end
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h1111_0000;
    step();
    imem.imem_ack = 1'b0;
    chk_bus("hold0", 1'b0, 32'h0, 1'b0);
    chk_if("hold0", 1'b1, 32'h0, 32'h1111_0000);

    // Stall in HOLD for five cycles.
    if_ctrl = C_STALL;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_if("stall", 1'b1, 32'h0, 32'h1111_0000);
      chk("stall.req", {31'd0, imem.imem_req}, 32'd0);
    end

    // Consume: next request at pc+4.
    if_ctrl = C_PIPE;
    step();
    chk_bus("pipe4", 1'b1, 32'h4, 1'b1);
    chk("pipe4.vld", {31'd0, if_valid}, 32'd0);

    // Ack tied high with continuous pipe: one instruction per two cycles.
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h2222_0004;
    step();
    chk_if("hold4", 1'b1, 32'h4, 32'h2222_0004);
    step();
    chk_bus("pipe8", 1'b1, 32'h8, 1'b1);
    imem.imem_rdata = 32'h3333_0008;
    step();
    chk_if("hold8", 1'b1, 32'h8, 32'h3333_0008);

    // Jump from HOLD to 0x40, request left outstanding.
    imem.imem_ack = 1'b0;
    if_ctrl = C_JUMP;
    jump_pc = 32'h0000_0040;
    step();
    chk_bus("j40", 1'b1, 32'h40, 1'b1);
    chk("j40.vld", {31'd0, if_valid}, 32'd0);

    // Jump to 0x103 while 0x40 is outstanding -> DROP, old address kept.
    jump_pc = 32'h0000_0103;
    step();
    chk_bus("drop40", 1'b1, 32'h40, 1'b1);
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hBAD0_0040;
    step();
    chk_bus("j100", 1'b1, 32'h100, 1'b1);
    chk("j100.vld", {31'd0, if_valid}, 32'd0);
    imem.imem_rdata = 32'h4444_0100;
    step();
    chk_if("hold100", 1'b1, 32'h100, 32'h4444_0100);

    // Two redirects in DROP: only the last one is fetched.
    imem.imem_ack = 1'b0;
    step();
    chk_bus("req104", 1'b1, 32'h104, 1'b1);
    if_ctrl = C_JUMP;
    jump_pc = 32'h0000_0200;
    step();
    chk_bus("drop_a", 1'b1, 32'h104, 1'b1);
    jump_pc = 32'h0000_0300;
    step();
    chk_bus("drop_b", 1'b1, 32'h104, 1'b1);
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hBAD0_0104;
    step();
    chk_bus("j300", 1'b1, 32'h300, 1'b1);
    imem.imem_rdata = 32'h5555_0300;
    step();
    chk_if("hold300", 1'b1, 32'h300, 32'h5555_0300);

    // Flush from HOLD refetches the held instruction.
    imem.imem_ack = 1'b0;
    if_ctrl = C_FLUSH;
    step();
    chk_bus("flush", 1'b1, 32'h300, 1'b1);
    chk("flush.vld", {31'd0, if_valid}, 32'd0);
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h6666_0300;
    step();
    chk_if("refetch", 1'b1, 32'h300, 32'h6666_0300);

    // Wrap: jump to 0xFFFFFFFF (aligned to ...FC), then pipe -> address 0.
    imem.imem_ack = 1'b0;
    if_ctrl = C_JUMP;
    jump_pc = 32'hFFFF_FFFF;
    step();
    chk_bus("jtop", 1'b1, 32'hFFFF_FFFC, 1'b1);
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'h7777_7777;
    step();
    chk_if("holdtop", 1'b1, 32'hFFFF_FFFC, 32'h7777_7777);
    imem.imem_ack = 1'b0;
    step();
    chk_bus("wrap", 1'b1, 32'h0, 1'b1);

    // Jump with ack in the same REQ cycle: straight to REQ at the target.
    if_ctrl = C_JUMP;
    jump_pc = 32'h0000_0080;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hBAD0_0000;
    step();
    chk_bus("jack", 1'b1, 32'h80, 1'b1);
    chk("jack.vld", {31'd0, if_valid}, 32'd0);

    // Reset mid-REQ with an ack present: everything back to reset values.
    if_ctrl = C_PIPE;
    imem.imem_ack = 1'b1;
    imem.imem_rdata = 32'hBAD0_0080;
    rst = 1'b1;
    step();
    chk_bus("rst2", 1'b0, 32'h0, 1'b0);
    chk_if("rst2", 1'b0, 32'h0, 32'h0000_0013);
    rst = 1'b0;
    imem.imem_ack = 1'b0;
    step();
    chk_bus("rel2", 1'b1, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
